// File: rtl/uart_tx_fifo_pkg.sv
// Shared register map, STATUS bit positions and CTRL field positions
// for the UART transmit buffer.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_LEVEL  = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_IRQ   = 3;

  localparam int CTRL_THR_LSB = 0;
  localparam int CTRL_THR_MSB = 4;
  localparam int CTRL_FLUSH   = 6;
  localparam int CTRL_IRQ_EN  = 7;

  localparam int THR_W = CTRL_THR_MSB - CTRL_THR_LSB + 1;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// First-word-fall-through FIFO with synchronous flush; a push into a full
// FIFO is accepted only when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int DBIT  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [DBIT-1:0] wdata,
  output logic [DBIT-1:0] head,
  output logic [AW:0]     count,
  output logic            full,
  output logic            empty
);

  logic [DBIT-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // NOTE: storage has no reset; validity is tracked by count, and leaving the
  // array out of the reset tree lets it map onto plain RAM cells.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Bus-facing transmit buffer: register window, FIFO toward the UART
// transmitter, sticky overflow flag and low-watermark interrupt.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wren,
  input  logic [1:0]      addr,
  input  logic [7:0]      data_i,
  output logic [7:0]      data_o,
  output logic [DBIT-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            irq
);

  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             flush;
  logic             wr_status;
  logic             wr_ctrl;
  logic             overflow;
  logic [THR_W-1:0] threshold;
  logic             irq_en;

  assign push      = wren & (reg_e'(addr) == REG_DATA);
  assign wr_status = wren & (reg_e'(addr) == REG_STATUS);
  assign wr_ctrl   = wren & (reg_e'(addr) == REG_CTRL);
  assign flush     = wr_ctrl & data_i[CTRL_FLUSH];
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  sync_fifo #(.DBIT(DBIT), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (data_i[DBIT-1:0]),
    .head  (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A new overflow beats a same-cycle clear request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      threshold <= '0;
      irq_en    <= 1'b0;
    end else begin
      if (push && full && !pop)              overflow <= 1'b1;
      else if (wr_status && data_i[ST_OVF])  overflow <= 1'b0;
      if (wr_ctrl) begin
        threshold <= data_i[CTRL_THR_MSB:CTRL_THR_LSB];
        irq_en    <= data_i[CTRL_IRQ_EN];
      end
    end
  end

  // Compare at 32 bits so thresholds at or above DEPTH hold irq high.
  assign irq = irq_en & (32'(count) <= 32'(threshold));

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave a latch behind.
  always_comb begin
    data_o = '0;
    unique case (reg_e'(addr))
      REG_DATA:   data_o = 8'(out_data);
      REG_STATUS: begin
        data_o[ST_EMPTY] = empty;
        data_o[ST_FULL]  = full;
        data_o[ST_OVF]   = overflow;
        data_o[ST_IRQ]   = irq;
      end
      REG_LEVEL:  data_o = 8'(count);
      REG_CTRL: begin
        data_o[CTRL_THR_MSB:CTRL_THR_LSB] = threshold;
        data_o[CTRL_IRQ_EN]               = irq_en;
      end
      default:    data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: stimulus maintains a byte-queue
// model and register state; a negedge monitor checks every transmitter handshake.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wren = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] data_i = '0;
  logic [7:0] data_o;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       irq;

  uart_tx_fifo #(.DBIT(8), .DEPTH(DEPTH), .AW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .wren      (wren),
    .addr      (addr),
    .data_i    (data_i),
    .data_o    (data_o),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  always #10 clock = ~clock;

  // Model state: bytes the transmitter must still receive, in order.
  logic [7:0] exp_q[$];
  bit         m_ovf    = 0;
  int         m_thr    = 0;
  bit         m_irq_en = 0;
  bit         mon_en   = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: at each falling edge compare valid and, on a handshake, the byte.
  always @(negedge clock) begin
    if (mon_en) begin
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected byte", int'(out_data), -1);
        else                   check("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  function automatic bit m_irq();
    return m_irq_en && (exp_q.size() <= m_thr);
  endfunction

  // One bus cycle; called just after a rising edge, returns just after the next.
  task automatic step(input bit w, input logic [1:0] a, input logic [7:0] d, input bit r);
    int lvl;
    bit pop_now, push_now, acc, fl;
    wren = w; addr = a; data_i = d; out_ready = r;
    lvl      = exp_q.size();
    pop_now  = (lvl != 0) && r;
    push_now = w && (a == 2'd0);
    acc      = push_now && (lvl < DEPTH || pop_now);
    fl       = w && (a == 2'd3) && d[6];
    @(posedge clock);
    if (fl)       exp_q.delete();
    else if (acc) exp_q.push_back(d);
    if (push_now && !acc)              m_ovf = 1;
    else if (w && a == 2'd1 && d[2])   m_ovf = 0;
    if (w && a == 2'd3) begin
      m_thr    = int'(d[4:0]);
      m_irq_en = d[7];
    end
    #1;
  endtask

  task automatic check_regs();
    int lvl;
    lvl  = exp_q.size();
    wren = 0; out_ready = 0;
    addr = 2'd1; #1;
    check("STATUS", int'(data_o),
          int'(lvl == 0) | (int'(lvl == DEPTH) << 1) | (int'(m_ovf) << 2) | (int'(m_irq()) << 3));
    addr = 2'd2; #1;
    check("LEVEL", int'(data_o), lvl);
    addr = 2'd3; #1;
    check("CTRL", int'(data_o), (int'(m_irq_en) << 7) | m_thr);
    check("irq", int'(irq), int'(m_irq()));
    if (lvl != 0) begin
      addr = 2'd0; #1;
      check("DATA", int'(data_o), int'(exp_q[0]));
      check("out_data head", int'(out_data), int'(exp_q[0]));
    end
    step(0, 2'd2, 8'h00, 0);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit r);
    step(1, 2'd0, b, r);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 2'd2, 8'h00, 1);
  endtask

  initial begin
    #25 reset = 1'b1;
    @(posedge clock); #1;
    mon_en = 1;

    // Reset state.
    check("reset out_valid", int'(out_valid), 0);
    check_regs();

    // Three bytes then drain in order.
    push_byte(8'h41, 0); push_byte(8'h42, 0); push_byte(8'h43, 0);
    check_regs();
    drain(3);
    check_regs();

    // Fill, overflow, clear overflow.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 0);
    push_byte(8'hAA, 0);
    check_regs();
    step(1, 2'd1, 8'h04, 0);
    check_regs();

    // Full with simultaneous pop: push accepted, no overflow.
    push_byte(8'h55, 1);
    check_regs();
    drain(DEPTH + 2);
    check_regs();

    // Low-watermark interrupt.
    for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i), 0);
    step(1, 2'd3, 8'h82, 0);
    check_regs();
    drain(1);
    check_regs();
    drain(1);
    check_regs();
    step(1, 2'd3, 8'h02, 0);
    check_regs();
    drain(4);

    // Flush with a concurrent handshake.
    for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i), 0);
    step(1, 2'd3, 8'h40, 1);
    check_regs();

    // Randomised traffic including wrap-around and register writes.
    for (int i = 0; i < 400; i++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 55)      push_byte(8'($urandom), $urandom_range(0, 1) == 1);
      else if (op < 85) step(0, 2'd2, 8'h00, $urandom_range(0, 1) == 1);
      else if (op < 90) step(1, 2'd1, 8'($urandom), $urandom_range(0, 1) == 1);
      else if (op < 96) step(1, 2'd3, 8'($urandom) & 8'hBF, $urandom_range(0, 1) == 1);
      else if (op < 97) step(1, 2'd3, 8'($urandom), $urandom_range(0, 1) == 1);
      else              check_regs();
    end
    check_regs();
    drain(DEPTH + 2);
    check_regs();

    // Asynchronous reset in the middle of a cycle with data queued.
    for (int i = 0; i < 3; i++) push_byte(8'h90 + 8'(i), 0);
    step(1, 2'd3, 8'h8F, 0);
    mon_en = 0;
    addr = 2'd1;
    #2 reset = 1'b0;
    #1;
    check("async reset out_valid", int'(out_valid), 0);
    check("async reset STATUS", int'(data_o), 8'h01);
    check("async reset irq", int'(irq), 0);
    exp_q.delete();
    m_ovf = 0; m_thr = 0; m_irq_en = 0;
    #2 reset = 1'b1;
    @(posedge clock); #1;
    mon_en = 1;
    check_regs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
